// File: rtl/rvfi_commit_serializer_if.sv
// rtl/rvfi_commit_serializer_if.sv - commit-side and drain-side handshake bundle
// Purpose: groups the per-channel commit records (in_*) with in_ready, and the
//          drained head record (out_*) with its out_valid/out_ready handshake.
// Modports: master = producer/consumer side, slave = rvfi_commit_serializer.
interface rvfi_commit_serializer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ORDER_W      = 64
);
  logic [NUM_CHANNELS-1:0] in_valid;
  logic [ORDER_W-1:0]      in_order    [NUM_CHANNELS];
  logic [31:0]             in_inst     [NUM_CHANNELS];
  logic [31:0]             in_pc_rdata [NUM_CHANNELS];
  logic [31:0]             in_pc_wdata [NUM_CHANNELS];
  logic [4:0]              in_rd_addr  [NUM_CHANNELS];
  logic [31:0]             in_rd_wdata [NUM_CHANNELS];
  logic                    in_ready;

  logic                    out_valid;
  logic                    out_ready;
  logic [ORDER_W-1:0]      out_order;
  logic [31:0]             out_inst;
  logic [31:0]             out_pc_rdata;
  logic [31:0]             out_pc_wdata;
  logic [4:0]              out_rd_addr;
  logic [31:0]             out_rd_wdata;

  modport master (
    output in_valid, in_order, in_inst, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata,
    input  in_ready,
    input  out_valid, out_order, out_inst, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata,
    output out_ready
  );

  modport slave (
    input  in_valid, in_order, in_inst, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata,
    output in_ready,
    output out_valid, out_order, out_inst, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata,
    input  out_ready
  );
endinterface

// File: rtl/rvfi_commit_serializer.sv
// rtl/rvfi_commit_serializer.sv - multi-channel RVFI commit FIFO with order/halt/segment checks
// Purpose: compacts up to NUM_CHANNELS retired records per cycle into a circular
//          FIFO and drains one per cycle; checks order continuity, detects halt
//          instructions and keeps segment instruction/cycle counters.
// Ports:   clk, rst_n (async active-low); bus (slave modport: commit in, drain out);
//          halted_o, err_order_o, err_overflow_o, err_order_got_o (sticky status);
//          seg_insts_o, seg_cycles_o, seg_done_o (segment counters).
module rvfi_commit_serializer #(
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH        = 16,
  parameter int ORDER_W      = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  rvfi_commit_serializer_if.slave bus,
  output logic               halted_o,
  output logic               err_order_o,
  output logic               err_overflow_o,
  output logic [ORDER_W-1:0] err_order_got_o,
  output logic [ORDER_W-1:0] seg_insts_o,
  output logic [ORDER_W-1:0] seg_cycles_o,
  output logic               seg_done_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Halt idioms: beq x0,x0,0 / jal x0,0 / slti x0,x0,-256; segment markers.
  localparam logic [31:0] INST_HALT_BEQ  = 32'h0000_0063;
  localparam logic [31:0] INST_HALT_JAL  = 32'h0000_006F;
  localparam logic [31:0] INST_HALT_SLTI = 32'hF000_2013;
  localparam logic [31:0] INST_SEG_START = 32'h0010_2013;
  localparam logic [31:0] INST_SEG_STOP  = 32'h0020_2013;

  logic [ORDER_W-1:0] mem_order_q    [DEPTH];
  logic [31:0]        mem_inst_q     [DEPTH];
  logic [31:0]        mem_pc_rdata_q [DEPTH];
  logic [31:0]        mem_pc_wdata_q [DEPTH];
  logic [4:0]         mem_rd_addr_q  [DEPTH];
  logic [31:0]        mem_rd_wdata_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic [ORDER_W-1:0] expect_q, expect_d;
  logic               err_order_q, err_order_d, err_overflow_q, err_overflow_d;
  logic [ORDER_W-1:0] err_got_q, err_got_d;
  logic               halted_q, halted_d;
  logic [ORDER_W-1:0] seg_insts_q, seg_insts_d, seg_cycles_q, seg_cycles_d;
  logic               seg_done_q, seg_done_d;

  logic [PTR_W-1:0]   slot [NUM_CHANNELS];
  logic [CNT_W-1:0]   pop;
  logic               any_valid, enq, overflow, out_valid_w, deq, halt_hit;
  logic [ORDER_W-1:0] head_order;
  logic [31:0]        head_inst, head_pc_rdata, head_pc_wdata;

  // Each valid channel lands at wr_ptr + (number of valid channels below it),
  // which compacts the group; the pointer sum wraps naturally modulo DEPTH.
  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      slot[c] = wr_ptr_q + pop[PTR_W-1:0];
      if (bus.in_valid[c]) pop = pop + CNT_W'(1);
    end
  end

  assign any_valid     = |bus.in_valid;
  assign enq           = in_ready_q && any_valid;
  assign overflow      = !in_ready_q && any_valid;
  assign out_valid_w   = (count_q != '0);
  assign deq           = out_valid_w && bus.out_ready;
  assign head_order    = mem_order_q[rd_ptr_q];
  assign head_inst     = mem_inst_q[rd_ptr_q];
  assign head_pc_rdata = mem_pc_rdata_q[rd_ptr_q];
  assign head_pc_wdata = mem_pc_wdata_q[rd_ptr_q];
  assign halt_hit      = (head_pc_rdata == head_pc_wdata) || (head_inst == INST_HALT_BEQ) ||
                         (head_inst == INST_HALT_JAL) || (head_inst == INST_HALT_SLTI);

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (bus.in_valid[c]) begin
          mem_order_q[slot[c]]    <= bus.in_order[c];
          mem_inst_q[slot[c]]     <= bus.in_inst[c];
          mem_pc_rdata_q[slot[c]] <= bus.in_pc_rdata[c];
          mem_pc_wdata_q[slot[c]] <= bus.in_pc_wdata[c];
          mem_rd_addr_q[slot[c]]  <= bus.in_rd_addr[c];
          mem_rd_wdata_q[slot[c]] <= bus.in_rd_wdata[c];
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    expect_d       = expect_q;
    err_order_d    = err_order_q;
    err_got_d      = err_got_q;
    err_overflow_d = err_overflow_q || overflow;
    halted_d       = halted_q;
    seg_insts_d    = seg_insts_q;
    seg_cycles_d   = seg_cycles_q;
    seg_done_d     = seg_done_q;

    if (enq) wr_ptr_d = wr_ptr_q + pop[PTR_W-1:0];
    count_d = count_q + (enq ? pop : '0) - (deq ? CNT_W'(1) : '0);

    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head_order == expect_q) begin
        expect_d = expect_q + ORDER_W'(1);
      end else begin
        // Resynchronise on the observed order so one gap reports only once.
        err_order_d = 1'b1;
        if (!err_order_q) err_got_d = head_order;
        expect_d = head_order + ORDER_W'(1);
      end
      if (halt_hit) halted_d = 1'b1;
    end

    in_ready_d = ((CNT_W'(DEPTH) - count_d) >= CNT_W'(NUM_CHANNELS)) && !halted_d;

    // Start marker wins over the freeze so a new segment can follow a stop.
    if (deq && (head_inst == INST_SEG_START)) begin
      seg_insts_d  = '0;
      seg_cycles_d = '0;
      seg_done_d   = 1'b0;
    end else if (!seg_done_q) begin
      seg_cycles_d = seg_cycles_q + ORDER_W'(1);
      if (deq) seg_insts_d = seg_insts_q + ORDER_W'(1);
      if (deq && (head_inst == INST_SEG_STOP)) seg_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      in_ready_q     <= 1'b0;
      expect_q       <= '0;
      err_order_q    <= 1'b0;
      err_got_q      <= '0;
      err_overflow_q <= 1'b0;
      halted_q       <= 1'b0;
      seg_insts_q    <= '0;
      seg_cycles_q   <= '0;
      seg_done_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      in_ready_q     <= in_ready_d;
      expect_q       <= expect_d;
      err_order_q    <= err_order_d;
      err_got_q      <= err_got_d;
      err_overflow_q <= err_overflow_d;
      halted_q       <= halted_d;
      seg_insts_q    <= seg_insts_d;
      seg_cycles_q   <= seg_cycles_d;
      seg_done_q     <= seg_done_d;
    end
  end

  // Head fields are masked while empty so stale slots never leak out.
  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_order    = out_valid_w ? head_order : '0;
  assign bus.out_inst     = out_valid_w ? head_inst : '0;
  assign bus.out_pc_rdata = out_valid_w ? head_pc_rdata : '0;
  assign bus.out_pc_wdata = out_valid_w ? head_pc_wdata : '0;
  assign bus.out_rd_addr  = out_valid_w ? mem_rd_addr_q[rd_ptr_q] : '0;
  assign bus.out_rd_wdata = out_valid_w ? mem_rd_wdata_q[rd_ptr_q] : '0;

  assign halted_o        = halted_q;
  assign err_order_o     = err_order_q;
  assign err_overflow_o  = err_overflow_q;
  assign err_order_got_o = err_got_q;
  assign seg_insts_o     = seg_insts_q;
  assign seg_cycles_o    = seg_cycles_q;
  assign seg_done_o      = seg_done_q;
endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// tb/tb_rvfi_commit_serializer.sv - directed self-checking bench for rvfi_commit_serializer
module tb_rvfi_commit_serializer;
  localparam int NC = 4;
  localparam int DEPTH = 16;
  localparam int OW = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL   = 32'h0000_006F;
  localparam logic [31:0] START = 32'h0010_2013;
  localparam logic [31:0] STOP  = 32'h0020_2013;

  logic clk = 1'b0;
  logic rst_n;
  logic halted, err_order, err_overflow, seg_done;
  logic [OW-1:0] err_order_got, seg_insts, seg_cycles;
  int n_pass = 0;
  int n_total = 0;

  rvfi_commit_serializer_if #(.NUM_CHANNELS(NC), .ORDER_W(OW)) bus ();

  rvfi_commit_serializer #(.NUM_CHANNELS(NC), .DEPTH(DEPTH), .ORDER_W(OW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .halted_o        (halted),
    .err_order_o     (err_order),
    .err_overflow_o  (err_overflow),
    .err_order_got_o (err_order_got),
    .seg_insts_o     (seg_insts),
    .seg_cycles_o    (seg_cycles),
    .seg_done_o      (seg_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid = '0;
    for (int c = 0; c < NC; c++) begin
      bus.in_order[c] = '0;
      bus.in_inst[c] = '0;
      bus.in_pc_rdata[c] = '0;
      bus.in_pc_wdata[c] = '0;
      bus.in_rd_addr[c] = '0;
      bus.in_rd_wdata[c] = '0;
    end
  endtask

  // Record with order o on channel c; pc_rdata = 0x1000 + 4*o, pc_wdata = pc_rdata + 4.
  task automatic put(input int c, input int o, input logic [31:0] inst);
    bus.in_valid[c] = 1'b1;
    bus.in_order[c] = 64'(o);
    bus.in_inst[c] = inst;
    bus.in_pc_rdata[c] = 32'h1000 + 32'(o) * 4;
    bus.in_pc_wdata[c] = 32'h1004 + 32'(o) * 4;
    bus.in_rd_addr[c] = 5'(o);
    bus.in_rd_wdata[c] = ~32'(o);
  endtask

  task automatic do_reset();
    clear_in();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_in();
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    n_total++; if ({bus.in_ready, bus.out_valid, halted, err_order, err_overflow, seg_done} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {bus.in_ready, bus.out_valid, halted, err_order, err_overflow, seg_done}); else n_pass++;
    n_total++; if ({seg_insts, seg_cycles, err_order_got, bus.out_order} !== '0)
      $display("FAIL reset_values: got %h/%h/%h/%h want all 0", seg_insts, seg_cycles, err_order_got, bus.out_order); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_rise: got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (seg_cycles !== 64'd1) $display("FAIL reset_seg_cycles_first: got %0d want 1", seg_cycles); else n_pass++;
  endtask

  task automatic test_single_stream();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clear_in();
      put(0, i, NOP);
      step();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_order !== 64'(i))
        $display("FAIL stream_order[%0d]: got v=%b order %0d want v=1 order %0d", i, bus.out_valid, bus.out_order, i); else n_pass++;
      n_total++; if (bus.out_pc_wdata !== 32'h1004 + 32'(i) * 4 || bus.out_rd_wdata !== ~32'(i) || bus.out_rd_addr !== 5'(i))
        $display("FAIL stream_fields[%0d]: got pcw %h wdata %h rd %0d", i, bus.out_pc_wdata, bus.out_rd_wdata, bus.out_rd_addr); else n_pass++;
    end
    clear_in();
    step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL stream_empty: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (err_order !== 1'b0) $display("FAIL stream_err_order: got %b want 0", err_order); else n_pass++;
    n_total++; if (seg_insts !== 64'd10) $display("FAIL stream_seg_insts: got %0d want 10", seg_insts); else n_pass++;
  endtask

  task automatic test_sparse();
    do_reset();
    put(1, 0, NOP);
    put(3, 1, NOP);
    step();
    clear_in();
    put(0, 2, NOP);
    put(2, 3, NOP);
    step();
    clear_in();
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_order !== 64'(j))
        $display("FAIL sparse_order[%0d]: got v=%b order %0d want %0d", j, bus.out_valid, bus.out_order, j); else n_pass++;
      step();
    end
    n_total++; if (bus.out_valid !== 1'b0 || err_order !== 1'b0)
      $display("FAIL sparse_end: got v=%b err_order=%b want 0/0", bus.out_valid, err_order); else n_pass++;
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int g = 0; g < 4; g++) begin
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL fill_ready[%0d]: got %b want 1", g, bus.in_ready); else n_pass++;
      for (int c = 0; c < NC; c++) put(c, 4 * g + c, NOP);
      step();
    end
    n_total++; if (bus.in_ready !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL fill_full: got in_ready=%b ovf=%b want 0/0", bus.in_ready, err_overflow); else n_pass++;
    for (int c = 0; c < NC; c++) put(c, 16 + c, NOP);
    step();
    clear_in();
    n_total++; if (err_overflow !== 1'b1) $display("FAIL overflow_flag: got %b want 1", err_overflow); else n_pass++;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_order !== 64'(j))
        $display("FAIL drain_order[%0d]: got v=%b order %0d", j, bus.out_valid, bus.out_order); else n_pass++;
      step();
    end
    // Move the pointers to 3 so the last of four full groups straddles 15 -> 0.
    put(0, 16, NOP);
    put(1, 17, NOP);
    put(2, 18, NOP);
    bus.out_ready = 1'b0;
    step();
    clear_in();
    bus.out_ready = 1'b1;
    step(); step(); step();
    bus.out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < NC; c++) put(c, 19 + 4 * g + c, NOP);
      step();
    end
    clear_in();
    bus.out_ready = 1'b1;
    for (int j = 19; j < 35; j++) begin
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_order !== 64'(j))
        $display("FAIL wrap_order[%0d]: got v=%b order %0d", j, bus.out_valid, bus.out_order); else n_pass++;
      step();
    end
    n_total++; if (err_order !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL wrap_end: got err=%b v=%b rdy=%b want 0/0/1", err_order, bus.out_valid, bus.in_ready); else n_pass++;
  endtask

  task automatic test_order_gap();
    int ords [4] = '{0, 1, 3, 4};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clear_in();
      if (i < 4) put(0, ords[i], NOP);
      step();
      if (i >= 1) begin
        n_total++; if (err_order !== (i >= 3))
          $display("FAIL gap_err[%0d]: got %b want %b", ords[i-1], err_order, (i >= 3)); else n_pass++;
      end
    end
    n_total++; if (err_order_got !== 64'd3) $display("FAIL gap_got: got %0d want 3", err_order_got); else n_pass++;
    clear_in();
    put(0, 5, NOP);
    step();
    clear_in();
    put(0, 7, NOP);
    step();
    clear_in();
    step();
    n_total++; if (err_order_got !== 64'd3 || err_order !== 1'b1)
      $display("FAIL gap_sticky: got err=%b got=%0d want 1/3", err_order, err_order_got); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < NC; c++) put(c, 4 * g + c, NOP);
      if (g == 0) begin
        bus.in_inst[1] = JAL;
        bus.in_pc_rdata[1] = 32'h6000_0010;
        bus.in_pc_wdata[1] = 32'h6000_0014;
      end
      step();
    end
    clear_in();
    bus.out_ready = 1'b1;
    step();
    n_total++; if (halted !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inst !== JAL)
      $display("FAIL halt_before: got halted=%b rdy=%b inst=%h", halted, bus.in_ready, bus.out_inst); else n_pass++;
    step();
    n_total++; if (halted !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL halt_set: got halted=%b rdy=%b want 1/0", halted, bus.in_ready); else n_pass++;
    for (int j = 2; j < 12; j++) begin
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_order !== 64'(j) || bus.in_ready !== 1'b0)
        $display("FAIL halt_drain[%0d]: got v=%b order %0d rdy=%b", j, bus.out_valid, bus.out_order, bus.in_ready); else n_pass++;
      step();
    end
    n_total++; if (bus.out_valid !== 1'b0 || halted !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL halt_end: got v=%b halted=%b rdy=%b want 0/1/0", bus.out_valid, halted, bus.in_ready); else n_pass++;
  endtask

  task automatic test_segment_reset();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clear_in();
      put(0, i, (i == 0) ? START : ((i == 6) ? STOP : NOP));
      step();
    end
    clear_in();
    step();
    n_total++; if (seg_insts !== 64'd6 || seg_cycles !== 64'd6 || seg_done !== 1'b1)
      $display("FAIL seg_stop: got insts=%0d cycles=%0d done=%b want 6/6/1", seg_insts, seg_cycles, seg_done); else n_pass++;
    for (int k = 0; k < 4; k++) step();
    n_total++; if (seg_insts !== 64'd6 || seg_cycles !== 64'd6)
      $display("FAIL seg_frozen: got insts=%0d cycles=%0d want 6/6", seg_insts, seg_cycles); else n_pass++;
    bus.out_ready = 1'b0;
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < NC; c++) put(c, 7 + 4 * g + c, NOP);
      step();
    end
    clear_in();
    bus.out_ready = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    n_total++; if ({bus.in_ready, bus.out_valid, halted, err_order, err_overflow, seg_done} !== 6'b0)
      $display("FAIL midreset_flags: got %b want 000000", {bus.in_ready, bus.out_valid, halted, err_order, err_overflow, seg_done}); else n_pass++;
    n_total++; if ({seg_insts, seg_cycles, bus.out_order, bus.out_inst} !== '0)
      $display("FAIL midreset_values: got %0d/%0d/%0d/%h want 0", seg_insts, seg_cycles, bus.out_order, bus.out_inst); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL midreset_after: got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_sparse();
    test_fill_wrap();
    test_order_gap();
    test_halt();
    test_segment_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rvfi_commit_serializer.md
# rvfi_commit_serializer

Synthesizable, parametrised successor to the 8-channel RVFI monitor. Accepts up to NUM_CHANNELS retired-instruction records per cycle from the ROB commit stage and buffers them in a circular FIFO. Drains them one per cycle under a valid/ready handshake to trace or checker logic. On the drain side, in hardware, it checks commit-order continuity, detects halt conditions and keeps segment IPC counters.

## Interface
Parameters:
- NUM_CHANNELS, 4, commit records presented per cycle (1..8)
- DEPTH, 16, FIFO entries; power of 2, ≥ NUM_CHANNELS
- ORDER_W, 64, width of order field and of all performance counters

Ports (`[N]` = per-channel array of NUM_CHANNELS):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid[N]  in  1  channel carries a retired instruction
- in_order[N]  in  ORDER_W  RVFI order
- in_inst[N]  in  32  instruction word
- in_pc_rdata[N], in_pc_wdata[N]  in  32  PC before and after the instruction
- in_rd_addr[N]  in  5  destination register
- in_rd_wdata[N]  in  32  rd write data
- in_ready  out  1  registered; FIFO can absorb a full NUM_CHANNELS group
- out_valid  out  1  head entry present
- out_ready  in  1  consumer accepts head
- out_order, out_inst, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata  out  —  head entry fields
- halted  out  1  sticky; halt instruction drained
- err_order  out  1  sticky; order discontinuity
- err_overflow  out  1  sticky; input presented while in_ready=0
- err_order_got  out  ORDER_W  order value of first discontinuous entry
- seg_insts, seg_cycles  out  ORDER_W  segment counters
- seg_done  out  1  sticky; stop marker drained

## Operation
- **Enqueue.** Enqueue fires when in_ready=1 and any in_valid is set.
  - Valid channels are written in ascending channel index into consecutive slots starting at the write pointer.
  - Invalid channels are skipped, so the stored group is compacted.
  - The write pointer advances by popcount(in_valid), modulo DEPTH.
- **Overflow.** If any in_valid is set while in_ready=0, all records that cycle are dropped and err_overflow is set.
- **Dequeue.** Dequeue fires when out_valid & out_ready. The read pointer advances by 1 modulo DEPTH. out_* always shows the head slot, and its value is stable while out_valid=1 and out_ready=0.
- **Occupancy.** count (width log2(DEPTH)+1) is updated as count + popcount(enqueued) − dequeue.
- **in_ready.** Next-state value is (DEPTH − count_next ≥ NUM_CHANNELS) && !halted_next.
- **Order check.** The check runs on each dequeue against an expect register (reset value 0).
  - If out_order == expect: expect ← expect + 1.
  - If out_order != expect: err_order ← 1; err_order_got captures out_order on the first mismatch only; expect ← out_order + 1 so checking resynchronises.
- **Halt.** A dequeued entry halts the block when pc_rdata == pc_wdata, or inst ∈ {0x00000063, 0x0000006F, 0xF0002013}.
  - halted ← 1 and stays set.
  - in_ready drops to 0. Already-buffered entries still drain.
- **Segment counters.**
  - seg_cycles increments every cycle after reset. seg_insts increments on every dequeue.
  - Dequeue of inst 0x00102013 (start marker): both counters are set to 0 that cycle; the marker itself is not counted.
  - Dequeue of inst 0x00202013 (stop marker): seg_done ← 1 and both counters freeze, with the stop marker counted.
  - A start marker drained after seg_done clears seg_done and resumes counting.
- **Counter width.** Counters wrap modulo 2^ORDER_W.

## Timing
- **Reset.** rst_n low asynchronously clears the pointers, count, expect, all sticky flags, err_order_got and the counters. Every output reads 0, including in_ready.
  - in_ready rises on the first clk edge after rst_n deasserts.
- **Latency.** A record enqueued at edge k is visible on out_* after edge k if the FIFO was empty (1-cycle latency). There is no combinational path from in_* to out_*.
- **Simultaneous enqueue and dequeue.** Both are legal in the same cycle, including when the FIFO is full: a dequeue at count=DEPTH still frees one slot, and in_ready reflects this on the next cycle.
- **Pointer wrap.** Pointer wrap mid-group is legal: a group whose slots cross DEPTH−1 → 0 is stored contiguously modulo DEPTH.
- **Empty FIFO.** With count=0, out_valid=0 and out_ready is ignored. There is no bypass.
- **Halt and dequeue in the same cycle.** Halt detection and the error flags update on the same edge as the dequeue that triggers them.
- **Reset mid-stream.** Buffered entries are discarded and no partial group survives.

## Test plan
- **Single-channel stream.** NUM_CHANNELS=4, DEPTH=16; one record per cycle, orders 0..9, out_ready=1. Expect out_order 0..9 each one cycle after input, err_order=0, seg_insts=10.
- **Sparse-valid compaction.** in_valid=4'b1010 with orders 0,1, then 4'b0101 with orders 2,3. Expect drain order 0,1,2,3 in four consecutive cycles.
- **Backpressure, fill and wrap.** Hold out_ready=0 and present 4 full groups. Expect count=16, in_ready=0 after the 4th group; a 5th presentation sets err_overflow. Release out_ready: 16 entries drain in order, and subsequent groups wrap the pointers correctly.
- **Order gap.** Drain orders 0,1,3,4. Expect err_order=1, err_order_got=3, and no further error at 4.
- **Halt.** Enqueue inst 0x0000006F with pc_rdata=0x60000010, followed by 2 more groups. Expect halted=1 on its dequeue, in_ready=0 thereafter, and the remaining buffered entries still drained.
- **Segment markers and reset.** Enqueue 0x00102013, 5 NOPs, then 0x00202013 over 12 cycles. Expect seg_insts=6, seg_done=1, seg_cycles frozen. Asserting rst_n=0 mid-drain zeroes every output immediately.
